// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over a req/ack
// handshake, holds the fetched word in the IR until the control unit retires it.
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic               instr_valid,
    input  logic               exec_done,
    input  logic               jump,
    input  logic               branch_sig,
    input  logic [ADDR_W-1:0]  target,
    output logic [ADDR_W-1:0]  pc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_instr;
    logic                w_take_ack;
    logic                w_retire;
    logic [ADDR_W-1:0]   w_pc_next;

    // Acks are only meaningful while a request is outstanding; stray ones leave the IR alone.
    assign w_take_ack = (r_state == S_FETCH) && imem_ack;
    assign w_retire   = (r_state == S_EXEC) && exec_done;
    assign w_pc_next  = (jump || branch_sig) ? target : r_pc + ADDR_W'(1);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (enable)     w_state_next = S_FETCH;
            S_FETCH: if (imem_ack)   w_state_next = S_EXEC;
            S_EXEC:  if (exec_done)  w_state_next = enable ? S_FETCH : S_IDLE;
            default:                 w_state_next = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_take_ack) r_instr <= imem_rdata;
            if (w_retire)   r_pc    <= w_pc_next;
        end
    end

    // All outputs decode directly from registers, so reset reaches them without a clock edge.
    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[INSTR_W-1 -: 4];
    assign instr_valid = (r_state == S_EXEC);
    assign pc          = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory responder with programmable wait states,
// a scoreboard of expected (pc, instr) pairs and a monitor that retires them.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic        instr_valid;
    logic        exec_done;
    logic        jump;
    logic        branch_sig;
    logic [7:0]  target;
    logic [7:0]  pc;

    fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .opcode     (opcode),
        .instr_valid(instr_valid),
        .exec_done  (exec_done),
        .jump       (jump),
        .branch_sig (branch_sig),
        .target     (target),
        .pc         (pc)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] word;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] mem [256];
    int          ack_wait;
    int          wait_cnt;
    int          n_pass;
    int          n_total;
    logic        prev_valid;
    bit          found;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Memory responder: acks after ack_wait request cycles; ack_wait=0 is a zero-wait ack.
    always @(negedge clock) begin
        if (imem_req) begin
            if (wait_cnt >= ack_wait) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr];
            end else begin
                imem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    // Monitor: every new instruction entering execute retires one scoreboard entry.
    always @(negedge clock) begin
        if (instr_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_instr: got pc=%h instr=%h expected none", pc, instr);
            end else begin
                mon_e = sb.pop_front();
                check("sb_pc",     32'(pc),     32'(mon_e.addr));
                check("sb_instr",  32'(instr),  32'(mon_e.word));
                check("sb_opcode", 32'(opcode), 32'(mon_e.word[15:12]));
            end
        end
        prev_valid = instr_valid;
    end

    initial begin
        n_pass     = 0;
        n_total    = 0;
        prev_valid = 1'b0;
        wait_cnt   = 0;
        ack_wait   = 0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        reset      = 1'b1;
        enable     = 1'b0;
        exec_done  = 1'b0;
        jump       = 1'b0;
        branch_sig = 1'b0;
        target     = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h00] = 16'hF000;
        mem[8'h01] = 16'h2456;
        mem[8'h02] = 16'h7ABC;
        mem[8'h03] = 16'h5A5A;
        mem[8'h04] = 16'hB000;
        mem[8'h40] = 16'h9111;
        mem[8'h41] = 16'hC000;
        mem[8'hFF] = 16'h1234;

        // Reset values with reset held
        #1;
        check("rst_pc",    32'(pc),          32'h00);
        check("rst_req",   32'(imem_req),    32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_addr",  32'(imem_addr),   32'h00);
        check("rst_instr", 32'(instr),       32'h0000);

        // Test 1: jump to 0x12, then pulse reset while fetching there
        @(negedge clock);
        reset = 1'b0;
        sb.push_back('{addr: 8'h00, word: 16'hF000});
        enable = 1'b1; exec_done = 1'b1; jump = 1'b1; target = 8'h12;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (instr_valid) found = 1'b1;
        end
        check("t1_exec_reached", 32'(found), 32'h1);
        ack_wait = 100;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (imem_req && pc == 8'h12) found = 1'b1;
        end
        check("t1_fetch_at_12", 32'(found), 32'h1);
        check("t1_addr", 32'(imem_addr), 32'h12);
        jump = 1'b0; exec_done = 1'b0; enable = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("t1_async_pc",    32'(pc),          32'h00);
        check("t1_async_req",   32'(imem_req),    32'h0);
        check("t1_async_valid", 32'(instr_valid), 32'h0);
        #1 reset = 1'b0;
        @(negedge clock);
        check("t1_idle_req", 32'(imem_req), 32'h0);
        check("t1_idle_pc",  32'(pc),       32'h00);
        ack_wait   = 0;
        mem[8'h00] = 16'h0123;

        // Test 2: sequential zero-wait run, halted during the third fetch
        sb.push_back('{addr: 8'h00, word: 16'h0123});
        sb.push_back('{addr: 8'h01, word: 16'h2456});
        sb.push_back('{addr: 8'h02, word: 16'h7ABC});
        enable = 1'b1; exec_done = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            check("t2_valid", 32'(instr_valid), 32'((i % 2) == 0));
            check("t2_req",   32'(imem_req),    32'((i % 2) == 1));
            if (i % 2 == 1) check("t2_addr", 32'(imem_addr), 32'((i - 1) / 2));
            if (i == 5) enable = 1'b0;
        end
        @(negedge clock);
        check("t2_halt_req", 32'(imem_req), 32'h0);
        check("t2_halt_pc",  32'(pc),       32'h03);

        // Test 3: three wait states on the fetch at 0x03
        ack_wait = 3;
        enable   = 1'b1;
        sb.push_back('{addr: 8'h03, word: 16'h5A5A});
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("t3_req",   32'(imem_req),    32'h1);
            check("t3_addr",  32'(imem_addr),   32'h03);
            check("t3_valid", 32'(instr_valid), 32'h0);
        end
        @(negedge clock);
        check("t3_valid_after_ack", 32'(instr_valid), 32'h1);
        enable = 1'b0;
        @(negedge clock);
        check("t3_halt_req", 32'(imem_req), 32'h0);
        check("t3_halt_pc",  32'(pc),       32'h04);
        ack_wait = 0;

        // Test 4: branch held without exec_done, then taken to 0x40
        sb.push_back('{addr: 8'h04, word: 16'hB000});
        sb.push_back('{addr: 8'h40, word: 16'h9111});
        enable = 1'b1; exec_done = 1'b0; branch_sig = 1'b1; target = 8'h40;
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("t4_hold_valid", 32'(instr_valid), 32'h1);
            check("t4_hold_pc",    32'(pc),          32'h04);
            check("t4_hold_op",    32'(opcode),      32'hB);
        end
        exec_done = 1'b1;
        @(negedge clock);
        check("t4_br_req",  32'(imem_req),  32'h1);
        check("t4_br_addr", 32'(imem_addr), 32'h40);
        branch_sig = 1'b0; enable = 1'b0;
        repeat (2) @(negedge clock);
        check("t4_halt_req", 32'(imem_req), 32'h0);
        check("t4_halt_pc",  32'(pc),       32'h41);

        // Test 5: jump to 0xFF, then sequential wrap to 0x00
        sb.push_back('{addr: 8'h41, word: 16'hC000});
        sb.push_back('{addr: 8'hFF, word: 16'h1234});
        sb.push_back('{addr: 8'h00, word: 16'h0123});
        enable = 1'b1; jump = 1'b1; target = 8'hFF;
        repeat (3) @(negedge clock);
        check("t5_jump_addr", 32'(imem_addr), 32'hFF);
        check("t5_jump_req",  32'(imem_req),  32'h1);
        jump = 1'b0;
        repeat (2) @(negedge clock);
        check("t5_wrap_pc",   32'(pc),        32'h00);
        check("t5_wrap_addr", 32'(imem_addr), 32'h00);
        check("t5_wrap_req",  32'(imem_req),  32'h1);
        enable = 1'b0;
        repeat (2) @(negedge clock);
        check("t5_halt_req", 32'(imem_req), 32'h0);
        check("t5_halt_pc",  32'(pc),       32'h01);

        // Test 6: enable dropped mid-fetch, then resumed at the new pc
        ack_wait = 2;
        enable   = 1'b1;
        sb.push_back('{addr: 8'h01, word: 16'h2456});
        @(negedge clock);
        check("t6_req",  32'(imem_req),  32'h1);
        check("t6_addr", 32'(imem_addr), 32'h01);
        enable = 1'b0;
        repeat (2) begin
            @(negedge clock);
            check("t6_req_held", 32'(imem_req), 32'h1);
        end
        @(negedge clock);
        check("t6_exec", 32'(instr_valid), 32'h1);
        @(negedge clock);
        check("t6_idle_req",   32'(imem_req),    32'h0);
        check("t6_idle_valid", 32'(instr_valid), 32'h0);
        check("t6_idle_pc",    32'(pc),          32'h02);
        @(negedge clock);
        check("t6_still_idle", 32'(imem_req), 32'h0);
        ack_wait = 0;
        enable   = 1'b1;
        sb.push_back('{addr: 8'h02, word: 16'h7ABC});
        @(negedge clock);
        check("t6_resume_req",  32'(imem_req),  32'h1);
        check("t6_resume_addr", 32'(imem_addr), 32'h02);
        enable = 1'b0;
        repeat (2) @(negedge clock);
        check("t6_final_req", 32'(imem_req), 32'h0);
        check("t6_final_pc",  32'(pc),       32'h03);

        repeat (3) @(negedge clock);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
